hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage MIPS core. It sits beside the IF/ID, ID/EX and EX/MEM pipeline registers and drives their hold and flush controls. It resolves load-use interlocks, flushes the front end on taken branches and jumps, and holds the pipeline while a multi-cycle mult/div occupies EX. It also produces EX-stage forwarding selects and keeps two saturating performance counters.

---
 rtl/hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: load-use
// interlock, branch/jump flush, multi-cycle mult/div hold, EX forwarding, stats.
module hazard_ctrl #(
    parameter int unsigned MULDIV_CYCLES = 32,
    parameter int unsigned CNT_W         = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rs,
    input  logic [4:0]  ex_rt,
    input  logic        ex_muldiv,
    input  logic        ex_branch_taken,
    input  logic        ex_jump,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_rd,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic        clr_stats,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_hold,
    output logic        id_ex_flush,
    output logic        ex_mem_bubble,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        muldiv_done,
    output logic        busy,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_events
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_MULDIV = 1'b1;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      stall_q, stall_d;
    logic [15:0]      flush_q, flush_d;

    logic redirect;
    logic load_use;
    logic redirect_taken;

    assign redirect = ex_branch_taken | ex_jump;
    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_comb begin
        fwd_a = FWD_RF;
        if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs)) begin
            fwd_a = FWD_MEM;
        end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs)) begin
            fwd_a = FWD_WB;
        end
        fwd_b = FWD_RF;
        if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rt)) begin
            fwd_b = FWD_MEM;
        end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rt)) begin
            fwd_b = FWD_WB;
        end
    end

    always_comb begin
        pc_write       = 1'b1;
        if_id_write    = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_hold     = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_bubble  = 1'b0;
        muldiv_done    = 1'b0;
        redirect_taken = 1'b0;
        state_d        = state_q;
        cnt_d          = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (redirect) begin
                    // wrong-path ID instruction is flushed, so its load-use is moot
                    if_id_flush    = 1'b1;
                    id_ex_flush    = 1'b1;
                    redirect_taken = 1'b1;
                end else if (ex_muldiv) begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_hold    = 1'b1;
                    ex_mem_bubble = 1'b1;
                    cnt_d         = CNT_W'(MULDIV_CYCLES - 2);
                    state_d       = ST_MULDIV;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    muldiv_done = 1'b1;
                    state_d     = ST_RUN;
                end else begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_hold    = 1'b1;
                    ex_mem_bubble = 1'b1;
                    cnt_d         = cnt_q - 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (clr_stats) begin
            stall_d = '0;
            flush_d = '0;
        end else begin
            if (!pc_write && (stall_q != '1)) stall_d = stall_q + 16'd1;
            if (redirect_taken && (flush_q != '1)) flush_d = flush_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign busy         = (state_q == ST_MULDIV);
    assign stall_cycles = stall_q;
    assign flush_events = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-position model of the controller's behaviour.
module tb_hazard_ctrl;

    localparam int MC = 4;

    logic        clk, rst_n;
    logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, mem_rd, wb_rd;
    logic        id_uses_rt, ex_mem_read, ex_muldiv, ex_branch_taken, ex_jump;
    logic        mem_reg_write, wb_reg_write, clr_stats;
    logic        pc_write, if_id_write, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_bubble;
    logic [1:0]  fwd_a, fwd_b;
    logic        muldiv_done, busy;
    logic [15:0] stall_cycles, flush_events;

    int total = 0;
    int bad   = 0;

    // model state: cycles already spent in the current mult/div (0 = none)
    int m_pos, m_stall, m_flush;
    logic e_pc, e_ifw, e_iff, e_hold, e_idf, e_bub, e_done, e_busy, e_redir;
    logic [1:0] e_fa, e_fb;

    hazard_ctrl #(.MULDIV_CYCLES(MC), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_muldiv(ex_muldiv),
        .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .clr_stats(clr_stats),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_hold(id_ex_hold), .id_ex_flush(id_ex_flush), .ex_mem_bubble(ex_mem_bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .muldiv_done(muldiv_done), .busy(busy),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (mem_reg_write && mem_rd != 0 && mem_rd == src) return 2'b10;
        if (wb_reg_write && wb_rd != 0 && wb_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_eval();
        logic redirect, lu, hold;
        redirect = ex_branch_taken | ex_jump;
        lu = ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
        e_pc = 1; e_ifw = 1; e_iff = 0; e_hold = 0; e_idf = 0; e_bub = 0; e_done = 0;
        e_redir = 0; hold = 0;
        e_busy = (m_pos != 0);
        e_fa = fwd_sel(ex_rs);
        e_fb = fwd_sel(ex_rt);
        if (m_pos == 0) begin
            if (redirect) begin
                e_iff = 1; e_idf = 1; e_redir = 1;
            end else if (ex_muldiv) begin
                hold = 1;
            end else if (lu) begin
                e_pc = 0; e_ifw = 0; e_idf = 1;
            end
        end else if (m_pos + 1 == MC) begin
            e_done = 1;
        end else begin
            hold = 1;
        end
        if (hold) begin
            e_pc = 0; e_ifw = 0; e_hold = 1; e_bub = 1;
        end
    endtask

    task automatic model_commit();
        if (m_pos == 0) m_pos = (e_hold) ? 1 : 0;
        else if (m_pos + 1 == MC) m_pos = 0;
        else m_pos = m_pos + 1;
        if (clr_stats) begin
            m_stall = 0; m_flush = 0;
        end else begin
            if (!e_pc && m_stall < 65535) m_stall++;
            if (e_redir && m_flush < 65535) m_flush++;
        end
    endtask

    // inputs are changed only at posedge+1; model follows the same edge
    task automatic tick();
        model_eval();
        @(posedge clk);
        if (rst_n) model_commit();
        else model_reset();
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_mem_read = 0; ex_rs = 0; ex_rt = 0;
        ex_muldiv = 0; ex_branch_taken = 0; ex_jump = 0; mem_reg_write = 0; mem_rd = 0;
        wb_reg_write = 0; wb_rd = 0; clr_stats = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        #3;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (muldiv_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", muldiv_done); end
        total++; if (pc_write !== 1'b1) begin bad++; $display("FAIL reset_pc_write got=%b exp=1", pc_write); end
        total++; if (stall_cycles !== 16'd0 || flush_events !== 16'd0) begin
            bad++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", stall_cycles, flush_events);
        end
        @(posedge clk); #1;
        rst_n = 1;
        tick();
    endtask

    task automatic test_load_use();
        idle_inputs();
        ex_mem_read = 1; ex_rt = 8; id_rs = 8;
        #1;
        total++; if ({pc_write, if_id_write, id_ex_flush} !== 3'b001) begin
            bad++; $display("FAIL load_use_stall got=%b exp=001", {pc_write, if_id_write, id_ex_flush});
        end
        tick();
        idle_inputs();
        #1;
        total++; if (stall_cycles !== 16'd1) begin bad++; $display("FAIL load_use_count got=%0d exp=1", stall_cycles); end
        ex_mem_read = 1; ex_rt = 0; id_rs = 0;
        #1;
        total++; if (pc_write !== 1'b1 || id_ex_flush !== 1'b0) begin
            bad++; $display("FAIL load_use_r0 got=%b%b exp=10", pc_write, id_ex_flush);
        end
        ex_rt = 9; id_rs = 3; id_rt = 9; id_uses_rt = 1;
        #1;
        total++; if (pc_write !== 1'b0) begin bad++; $display("FAIL load_use_rt got=%b exp=0", pc_write); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_redirect();
        int f0;
        idle_inputs();
        f0 = m_flush;
        ex_mem_read = 1; ex_rt = 8; id_rs = 8; ex_branch_taken = 1;
        #1;
        total++; if ({if_id_flush, id_ex_flush, pc_write, if_id_write} !== 4'b1111) begin
            bad++; $display("FAIL redirect_ctrl got=%b exp=1111", {if_id_flush, id_ex_flush, pc_write, if_id_write});
        end
        tick();
        idle_inputs();
        #1;
        total++; if (flush_events !== 16'(f0 + 1)) begin
            bad++; $display("FAIL redirect_count got=%0d exp=%0d", flush_events, f0 + 1);
        end
        total++; if (stall_cycles !== 16'(m_stall)) begin
            bad++; $display("FAIL redirect_nostall got=%0d exp=%0d", stall_cycles, m_stall);
        end
    endtask

    task automatic test_muldiv();
        int busy_n, low_n, done_n, s0;
        idle_inputs();
        clr_stats = 1; tick(); clr_stats = 0;
        s0 = m_stall;
        busy_n = 0; low_n = 0; done_n = 0;
        ex_muldiv = 1; ex_mem_read = 1; ex_rt = 4; id_rs = 4;
        for (int c = 0; c < MC; c++) begin
            #1; model_eval();
            total++; if ({busy, pc_write, muldiv_done, id_ex_hold, ex_mem_bubble} !==
                         {e_busy, e_pc, e_done, e_hold, e_bub}) begin
                bad++; $display("FAIL muldiv_cycle%0d got=%b exp=%b", c,
                    {busy, pc_write, muldiv_done, id_ex_hold, ex_mem_bubble}, {e_busy, e_pc, e_done, e_hold, e_bub});
            end
            busy_n += busy; low_n += !pc_write; done_n += muldiv_done;
            if (muldiv_done) ex_muldiv = 0;
            tick();
            ex_muldiv = (c < MC - 1) ? 1'b1 : 1'b0;
        end
        ex_muldiv = 0;
        total++; if (busy_n != 3 || low_n != 3 || done_n != 1) begin
            bad++; $display("FAIL muldiv_shape got busy=%0d low=%0d done=%0d exp 3/3/1", busy_n, low_n, done_n);
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL muldiv_return got=%b exp=0", busy); end
        // ID load-use held behind the mult is seen again after release
        total++; if (pc_write !== 1'b0 || id_ex_flush !== 1'b1) begin
            bad++; $display("FAIL muldiv_reeval got=%b%b exp=01", pc_write, id_ex_flush);
        end
        tick();
        idle_inputs(); #1;
        total++; if (stall_cycles !== 16'(s0 + 4)) begin
            bad++; $display("FAIL muldiv_stalls got=%0d exp=%0d", stall_cycles, s0 + 4);
        end
    endtask

    task automatic test_back_to_back();
        int done_n;
        idle_inputs();
        done_n = 0;
        ex_muldiv = 1;
        for (int c = 0; c < MC + 1; c++) begin
            #1; done_n += muldiv_done; tick();
        end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_second_busy got=%b exp=1", busy); end
        ex_muldiv = 0; rst_n = 0;
        model_reset();
        #1;
        total++; if (busy !== 1'b0 || muldiv_done !== 1'b0 || pc_write !== 1'b1 || id_ex_hold !== 1'b0) begin
            bad++; $display("FAIL b2b_reset_abort got=%b%b%b%b exp=0010", busy, muldiv_done, pc_write, id_ex_hold);
        end
        tick(); tick();
        rst_n = 1;
        for (int c = 0; c < MC + 2; c++) begin
            #1; done_n += muldiv_done; tick();
        end
        total++; if (done_n != 1) begin bad++; $display("FAIL b2b_pulses got=%0d exp=1 before abort", done_n); end
    endtask

    task automatic test_forward();
        idle_inputs();
        ex_rs = 5; ex_rt = 7; mem_rd = 5; wb_rd = 5; mem_reg_write = 1; wb_reg_write = 1;
        #1;
        total++; if (fwd_a !== 2'b10) begin bad++; $display("FAIL fwd_mem got=%b exp=10", fwd_a); end
        mem_reg_write = 0; #1;
        total++; if (fwd_a !== 2'b01) begin bad++; $display("FAIL fwd_wb got=%b exp=01", fwd_a); end
        mem_reg_write = 1; mem_rd = 0; wb_rd = 0; ex_rs = 0; #1;
        total++; if (fwd_a !== 2'b00) begin bad++; $display("FAIL fwd_r0 got=%b exp=00", fwd_a); end
        ex_rt = 7; mem_rd = 7; wb_rd = 7; #1;
        total++; if (fwd_b !== 2'b10 || fwd_a !== 2'b00) begin
            bad++; $display("FAIL fwd_b got=%b/%b exp=10/00", fwd_b, fwd_a);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
            mem_rd = 5'($urandom_range(0, 3)); wb_rd = 5'($urandom_range(0, 3));
            id_uses_rt = 1'($urandom); ex_mem_read = 1'($urandom);
            mem_reg_write = 1'($urandom); wb_reg_write = 1'($urandom);
            ex_muldiv = ($urandom_range(0, 5) == 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            ex_jump = ($urandom_range(0, 11) == 0);
            clr_stats = ($urandom_range(0, 63) == 0);
            #1; model_eval();
            total++; if ({pc_write, if_id_write, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_bubble, muldiv_done, busy} !==
                         {e_pc, e_ifw, e_iff, e_hold, e_idf, e_bub, e_done, e_busy}) begin
                bad++; $display("FAIL rand_ctrl n=%0d got=%b exp=%b", n,
                    {pc_write, if_id_write, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_bubble, muldiv_done, busy},
                    {e_pc, e_ifw, e_iff, e_hold, e_idf, e_bub, e_done, e_busy});
            end
            total++; if ({fwd_a, fwd_b} !== {e_fa, e_fb}) begin
                bad++; $display("FAIL rand_fwd n=%0d got=%b exp=%b", n, {fwd_a, fwd_b}, {e_fa, e_fb});
            end
            total++; if (stall_cycles !== 16'(m_stall) || flush_events !== 16'(m_flush)) begin
                bad++; $display("FAIL rand_stats n=%0d got=%0d/%0d exp=%0d/%0d", n,
                    stall_cycles, flush_events, m_stall, m_flush);
            end
            tick();
        end
        idle_inputs();
        for (int c = 0; c < MC; c++) tick();
    endtask

    task automatic test_saturation();
        idle_inputs();
        clr_stats = 1; tick(); clr_stats = 0;
        ex_mem_read = 1; ex_rt = 6; id_rs = 6;
        for (int c = 0; c < 65535; c++) tick();
        total++; if (stall_cycles !== 16'hFFFF) begin bad++; $display("FAIL sat_reach got=%h exp=ffff", stall_cycles); end
        tick(); tick();
        total++; if (stall_cycles !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", stall_cycles); end
        clr_stats = 1;
        tick();
        clr_stats = 0;
        total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL sat_clear got=%h exp=0", stall_cycles); end
        tick();
        total++; if (stall_cycles !== 16'(m_stall)) begin
            bad++; $display("FAIL sat_after_clear got=%0d exp=%0d", stall_cycles, m_stall);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_redirect();
        test_muldiv();
        test_back_to_back();
        test_forward();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
